// File: rtl/motor_ramp_ctrl.sv
// Command stage in front of the PWM driver: latches speed/direction commands,
// slew-limits duty and reverses only through ramp-to-zero plus a dead time.
module motor_ramp_ctrl #(
   parameter int RAMP_DIV    = 250,
   parameter int STEP        = 4,
   parameter int DEAD_CYCLES = 50,
   parameter int DUTY_MAX    = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_duty,
   input  logic       cmd_dir,
   input  logic       cmd_brake,
   input  logic       cmd_enable,
   input  logic       estop,
   output logic [7:0] duty_cycle,
   output logic       direction,
   output logic       motorbrake,
   output logic       pwm_en,
   output logic       busy
);

   localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
   localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);
   localparam logic [7:0]    DMAX       = (DUTY_MAX > 255) ? 8'd255 : 8'(DUTY_MAX);
   localparam logic [7:0]    STEP8      = (STEP > 255) ? 8'd255 : 8'(STEP);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_REVERSE,
      ST_DEAD,
      ST_BRAKE
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [DW-1:0] r_dead_cnt;
   logic [7:0]    r_target;
   logic          r_pend_dir;
   logic [7:0]    r_duty;
   logic          r_dir;
   logic          r_brake;
   logic          r_pwm_en;
   logic          r_busy;

   state_t        w_state_next;
   logic [DW-1:0] w_dead_next;
   logic [7:0]    w_target_next;
   logic          w_pend_next;
   logic [7:0]    w_duty_next;
   logic          w_dir_next;
   logic          w_brake_next;
   logic          w_pwm_en_next;
   logic          w_busy_next;

   logic          w_tick;
   logic          w_accept;
   logic [7:0]    w_cmd_target;
   logic [7:0]    w_tgt_eff;
   logic [7:0]    w_duty_down;

   // Move one STEP toward the target, landing exactly on it when closer than STEP.
   function automatic logic [7:0] f_ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [7:0] res;
      res = cur;
      if (cur < tgt) begin
         res = ((tgt - cur) > STEP8) ? (cur + STEP8) : tgt;
      end else if (cur > tgt) begin
         res = ((cur - tgt) > STEP8) ? (cur - STEP8) : tgt;
      end
      return res;
   endfunction

   assign w_tick       = (r_presc == PRESC_LAST);
   assign cmd_ready    = !reset && ((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_BRAKE));
   assign w_accept     = cmd_valid && cmd_ready;
   assign w_cmd_target = (cmd_duty > DMAX) ? DMAX : cmd_duty;
   assign w_tgt_eff    = w_accept ? w_cmd_target : r_target;
   assign w_duty_down  = (r_duty > STEP8) ? (r_duty - STEP8) : 8'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_dead_next   = r_dead_cnt;
      w_target_next = r_target;
      w_pend_next   = r_pend_dir;
      w_duty_next   = r_duty;
      w_dir_next    = r_dir;
      w_brake_next  = r_brake;
      w_pwm_en_next = r_pwm_en;

      if (estop) begin
         // Emergency stop overrides everything; commands are still handshaken but ignored.
         w_state_next  = ST_BRAKE;
         w_duty_next   = 8'd0;
         w_brake_next  = 1'b1;
         w_pwm_en_next = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_duty_next   = 8'd0;
               w_pwm_en_next = 1'b0;
               w_brake_next  = 1'b0;
               if (w_accept && cmd_enable) begin
                  w_target_next = w_cmd_target;
                  w_pwm_en_next = 1'b1;
                  if (cmd_brake) begin
                     w_state_next = ST_BRAKE;
                     w_brake_next = 1'b1;
                  end else begin
                     w_state_next = ST_RUN;
                     w_dir_next   = cmd_dir;
                  end
               end
            end

            ST_RUN: begin
               if (w_accept && !cmd_enable) begin
                  w_state_next  = ST_IDLE;
                  w_duty_next   = 8'd0;
                  w_pwm_en_next = 1'b0;
               end else if (w_accept && cmd_brake) begin
                  w_state_next  = ST_BRAKE;
                  w_duty_next   = 8'd0;
                  w_brake_next  = 1'b1;
                  w_pwm_en_next = 1'b1;
               end else if (w_accept && (cmd_dir != r_dir)) begin
                  w_target_next = w_cmd_target;
                  w_pend_next   = cmd_dir;
                  if (r_duty != 8'd0) begin
                     w_state_next = ST_REVERSE;
                  end else begin
                     w_state_next  = ST_DEAD;
                     w_pwm_en_next = 1'b0;
                     w_dead_next   = '0;
                  end
               end else begin
                  w_target_next = w_tgt_eff;
                  if (w_tick) begin
                     w_duty_next = f_ramp_toward(r_duty, w_tgt_eff);
                  end
               end
            end

            ST_REVERSE: begin
               // The bridge is switched off on the same edge duty reaches zero.
               if (r_duty == 8'd0) begin
                  w_state_next  = ST_DEAD;
                  w_pwm_en_next = 1'b0;
                  w_dead_next   = '0;
               end else if (w_tick) begin
                  w_duty_next = w_duty_down;
                  if (w_duty_down == 8'd0) begin
                     w_state_next  = ST_DEAD;
                     w_pwm_en_next = 1'b0;
                     w_dead_next   = '0;
                  end
               end
            end

            ST_DEAD: begin
               w_duty_next   = 8'd0;
               w_pwm_en_next = 1'b0;
               w_brake_next  = 1'b0;
               if (r_dead_cnt == DEAD_LAST) begin
                  w_state_next  = ST_RUN;
                  w_dir_next    = r_pend_dir;
                  w_pwm_en_next = 1'b1;
               end else begin
                  w_dead_next = r_dead_cnt + 1'b1;
               end
            end

            ST_BRAKE: begin
               w_duty_next   = 8'd0;
               w_brake_next  = 1'b1;
               w_pwm_en_next = 1'b1;
               if (w_accept && !cmd_enable) begin
                  w_state_next  = ST_IDLE;
                  w_brake_next  = 1'b0;
                  w_pwm_en_next = 1'b0;
               end else if (w_accept && !cmd_brake) begin
                  w_state_next  = ST_DEAD;
                  w_brake_next  = 1'b0;
                  w_pwm_en_next = 1'b0;
                  w_dead_next   = '0;
                  w_pend_next   = cmd_dir;
                  w_target_next = w_cmd_target;
               end
            end

            default: begin
               w_state_next  = ST_IDLE;
               w_duty_next   = 8'd0;
               w_pwm_en_next = 1'b0;
               w_brake_next  = 1'b0;
            end
         endcase
      end

      w_busy_next = (w_state_next == ST_REVERSE) || (w_state_next == ST_DEAD) ||
                    ((w_state_next == ST_RUN) && (w_duty_next != w_target_next));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_dead_cnt <= '0;
         r_target   <= 8'd0;
         r_pend_dir <= 1'b1;
         r_duty     <= 8'd0;
         r_dir      <= 1'b1;
         r_brake    <= 1'b0;
         r_pwm_en   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_dead_cnt <= w_dead_next;
         r_target   <= w_target_next;
         r_pend_dir <= w_pend_next;
         r_duty     <= w_duty_next;
         r_dir      <= w_dir_next;
         r_brake    <= w_brake_next;
         r_pwm_en   <= w_pwm_en_next;
         r_busy     <= w_busy_next;
      end
   end

   assign duty_cycle = r_duty;
   assign direction  = r_dir;
   assign motorbrake = r_brake;
   assign pwm_en     = r_pwm_en;
   assign busy       = r_busy;

endmodule
